// File: rtl/ram_1c_1r_1w.sv
// ---------------------------------------------------------------------------
// ram_1c_1r_1w
// Single-clock RAM with one write port and one registered read port.
// Reading and writing the same address on the same edge returns the old word.
//
// Parameters:
//   Width           data word width in bits
//   Depth           number of words (any value >= 2)
//   ReportCollision when non-zero, a same-address read/write on one edge
//                   fires an assertion in simulation
//
// Ports:
//   clk        in   clock
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write address
//   i_wr_data  in   write data
//   i_rd_en    in   read strobe; o_rd_data holds while low
//   i_rd_addr  in   read address
//   o_rd_data  out  word at i_rd_addr, one edge after the request
// ---------------------------------------------------------------------------
module ram_1c_1r_1w #(
  parameter  int Width           = 8,
  parameter  int Depth           = 128,
  parameter  int ReportCollision = 0,
  localparam int AddrBits        = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [AddrBits-1:0] i_wr_addr,
  input  logic [Width-1:0]    i_wr_data,
  input  logic                i_rd_en,
  input  logic [AddrBits-1:0] i_rd_addr,
  output logic [Width-1:0]    o_rd_data
);

  // NOTE: storage has no reset; clearing a RAM array on reset would stop it
  // mapping onto block memory, and the FIFO never reads a word it did not write.
  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd_data;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

  a_no_collision : assert property (@(posedge clk)
    !((ReportCollision != 0) && i_wr_en && i_rd_en && (i_wr_addr == i_rd_addr)));

endmodule

// File: rtl/fifo_1clk_prot.sv
// ---------------------------------------------------------------------------
// fifo_1clk_prot
// Single-clock look-ahead FIFO for the trace datapath. Refuses writes when
// full and reads when empty without touching its pointers, records such
// events in sticky flags, offers almost-full/almost-empty levels, a
// synchronous flush and a peak-occupancy watermark.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   flush          synchronous clear of contents (drops same-cycle requests)
//   wr_en/wr_data  write request and data
//   full           no free entries
//   almost_full    used >= AfullLevel
//   rd_en          pops the word currently on rd_data
//   rd_data        head word, valid while empty=0
//   empty          no readable entry
//   almost_empty   used <= AemptyLevel
//   used           entry count
//   max_used       peak of used since the last stat_clr
//   overflow       sticky: a write was refused
//   underflow      sticky: a read was refused
//   stat_clr       clears overflow, underflow and max_used
// ---------------------------------------------------------------------------
module fifo_1clk_prot #(
  parameter  int Width       = 8,
  parameter  int Depth       = 128,
  parameter  int AfullLevel  = Depth - 2,
  parameter  int AemptyLevel = 1,
  localparam int AddrBits    = $clog2(Depth),
  localparam int UsedBits    = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [Width-1:0]    wr_data,
  output logic                full,
  output logic                almost_full,
  input  logic                rd_en,
  output logic [Width-1:0]    rd_data,
  output logic                empty,
  output logic                almost_empty,
  output logic [UsedBits-1:0] used,
  output logic [UsedBits-1:0] max_used,
  output logic                overflow,
  output logic                underflow,
  input  logic                stat_clr
);

  // Pointer = {phase, address}; the phase flips each time the address wraps.
  localparam int PtrBits = AddrBits + 1;

  function automatic logic [PtrBits-1:0] inc_ptr(input logic [PtrBits-1:0] i_ptr);
    logic [AddrBits-1:0] v_addr;
    v_addr = i_ptr[AddrBits-1:0];
    if (v_addr == AddrBits'(Depth - 1)) begin
      return {~i_ptr[PtrBits-1], {AddrBits{1'b0}}};
    end
    return {i_ptr[PtrBits-1], v_addr + AddrBits'(1)};
  endfunction

  logic [PtrBits-1:0]  r_wr_ptr;
  logic [PtrBits-1:0]  r_rd_ptr;
  logic [UsedBits-1:0] r_used;
  logic [UsedBits-1:0] r_max_used;
  logic                r_empty;
  logic                r_full;
  logic                r_afull;
  logic                r_aempty;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_wr_refused;
  logic                w_rd_refused;
  logic [PtrBits-1:0]  w_wr_ptr_next;
  logic [PtrBits-1:0]  w_rd_ptr_next;
  logic [UsedBits-1:0] w_used_next;
  logic [UsedBits-1:0] w_max_next;
  logic                w_empty_next;

  assign w_wr_acc     = wr_en & ~r_full  & ~flush;
  assign w_rd_acc     = rd_en & ~r_empty & ~flush;
  assign w_wr_refused = wr_en &  r_full  & ~flush;
  assign w_rd_refused = rd_en &  r_empty & ~flush;

  // NOTE: every signal gets a default before any branch, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_used_next   = r_used;
    if (flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_used_next   = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_next = inc_ptr(r_wr_ptr);
      if (w_rd_acc) w_rd_ptr_next = inc_ptr(r_rd_ptr);
      w_used_next = r_used + UsedBits'(w_wr_acc) - UsedBits'(w_rd_acc);
    end
  end

  // Empty compares against the pre-edge write pointer: a pop to empty shows
  // at once, while a fresh write into an empty FIFO is hidden for one more
  // cycle so the head read never lands on the word being written.
  assign w_empty_next = flush | (w_rd_ptr_next == r_wr_ptr);

  always_comb begin
    w_max_next = r_max_used;
    if (stat_clr) begin
      w_max_next = w_used_next;
    end else if (w_used_next > r_max_used) begin
      w_max_next = w_used_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_used      <= '0;
      r_max_used  <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_afull     <= (AfullLevel <= 0);
      r_aempty    <= (AemptyLevel >= 0);
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_used      <= w_used_next;
      r_max_used  <= w_max_next;
      r_empty     <= w_empty_next;
      r_full      <= (w_used_next == UsedBits'(Depth));
      r_afull     <= (w_used_next >= UsedBits'(AfullLevel));
      r_aempty    <= (w_used_next <= UsedBits'(AemptyLevel));
      // A refused request in the same cycle as stat_clr keeps its flag set.
      r_overflow  <= w_wr_refused | (r_overflow  & ~stat_clr);
      r_underflow <= w_rd_refused | (r_underflow & ~stat_clr);
    end
  end

  // The RAM is addressed with the next read pointer so the new head word is
  // already registered on rd_data in the cycle after a pop.
  ram_1c_1r_1w #(
    .Width          (Width),
    .Depth          (Depth),
    .ReportCollision(0)
  ) u_ram (
    .clk      (clk),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr[AddrBits-1:0]),
    .i_wr_data(wr_data),
    .i_rd_en  (1'b1),
    .i_rd_addr(w_rd_ptr_next[AddrBits-1:0]),
    .o_rd_data(rd_data)
  );

  assign full         = r_full;
  assign almost_full  = r_afull;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign used         = r_used;
  assign max_used     = r_max_used;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_1clk_prot.sv
// ---------------------------------------------------------------------------
// tb_fifo_1clk_prot
// Self-checking bench for fifo_1clk_prot (Depth=5, Width=8, AfullLevel=4,
// AemptyLevel=1). A queue-based model tracks contents and flags; a negedge
// process compares every output against it each cycle. Directed sequences
// with literal expectations pin the model, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_fifo_1clk_prot;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int UB = $clog2(D + 1);

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          flush    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [W-1:0]  wr_data  = '0;
  logic          rd_en    = 1'b0;
  logic          stat_clr = 1'b0;
  logic          full;
  logic          almost_full;
  logic [W-1:0]  rd_data;
  logic          empty;
  logic          almost_empty;
  logic [UB-1:0] used;
  logic [UB-1:0] max_used;
  logic          overflow;
  logic          underflow;

  fifo_1clk_prot #(
    .Width      (W),
    .Depth      (D),
    .AfullLevel (AF),
    .AemptyLevel(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .almost_empty(almost_empty),
    .used        (used),
    .max_used    (max_used),
    .overflow    (overflow),
    .underflow   (underflow),
    .stat_clr    (stat_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] q[$];
  bit m_empty  = 1'b1;
  bit m_full   = 1'b0;
  bit m_afull  = 1'b0;
  bit m_aempty = 1'b1;
  bit m_ovf    = 1'b0;
  bit m_udf    = 1'b0;
  int m_max    = 0;
  bit checking = 1'b0;

  always @(posedge clk) begin
    bit wacc, racc, wref, rref, none_before_write;
    if (rst) begin
      q.delete();
      m_empty  = 1'b1;
      m_full   = 1'b0;
      m_afull  = (0 >= AF);
      m_aempty = (0 <= AE);
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_max    = 0;
      checking = 1'b1;
    end else begin
      wacc = wr_en && !m_full  && !flush;
      racc = rd_en && !m_empty && !flush;
      wref = wr_en &&  m_full  && !flush;
      rref = rd_en &&  m_empty && !flush;
      if (flush) begin
        q.delete();
        none_before_write = 1'b1;
      end else begin
        if (racc) void'(q.pop_front());
        // Readability only counts words already stored before this edge.
        none_before_write = (q.size() == 0);
        if (wacc) q.push_back(wr_data);
      end
      m_empty  = none_before_write;
      m_full   = (q.size() == D);
      m_afull  = (q.size() >= AF);
      m_aempty = (q.size() <= AE);
      if (stat_clr)           m_max = q.size();
      else if (q.size() > m_max) m_max = q.size();
      m_ovf = wref || (m_ovf && !stat_clr);
      m_udf = rref || (m_udf && !stat_clr);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("empty",        empty,        m_empty);
      check("full",         full,         m_full);
      check("almost_full",  almost_full,  m_afull);
      check("almost_empty", almost_empty, m_aempty);
      check("used",         used,         q.size());
      check("max_used",     max_used,     m_max);
      check("overflow",     overflow,     m_ovf);
      check("underflow",    underflow,    m_udf);
      if (!m_empty && q.size() > 0) check("rd_data", rd_data, q[0]);
    end
  end

  // One clock cycle with the given inputs; returns #1 after the edge.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit f, input bit s);
    wr_en    = w;
    wr_data  = d;
    rd_en    = r;
    flush    = f;
    stat_clr = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wp, rp;
    rst = 1'b1;
    repeat (2) step(0, 8'h00, 0, 0, 0);
    rst = 1'b0;
    check("rst empty",     empty,        1);
    check("rst aempty",    almost_empty, 1);
    check("rst full",      full,         0);
    check("rst afull",     almost_full,  0);
    check("rst used",      used,         0);
    check("rst max_used",  max_used,     0);
    check("rst overflow",  overflow,     0);
    check("rst underflow", underflow,    0);

    // Read on empty, then a write: empty held one extra cycle.
    step(0, 8'h00, 1, 0, 0);
    check("udf set",       underflow, 1);
    check("udf used",      used,      0);
    step(1, 8'h42, 0, 0, 0);
    check("wr hold empty", empty,     1);
    check("wr used",       used,      1);
    step(0, 8'h00, 0, 0, 0);
    check("wr E+1 empty",  empty,     0);
    check("wr E+1 data",   rd_data,   8'h42);
    step(0, 8'h00, 1, 0, 0);
    check("pop empty",     empty,     1);
    step(0, 8'h00, 0, 0, 1);
    check("clr udf",       underflow, 0);

    // Fill to full with threshold checks, then overflow.
    for (int i = 0; i < D; i++) begin
      step(1, 8'(8'h11 + i), 0, 0, 0);
      check("fill used",   used,         i + 1);
      check("fill aempty", almost_empty, (i + 1) <= AE);
      check("fill afull",  almost_full,  (i + 1) >= AF);
    end
    check("fill full", full, 1);
    step(1, 8'h99, 0, 0, 0);
    check("ovf set",  overflow, 1);
    check("ovf used", used,     5);
    check("ovf max",  max_used, 5);
    for (int i = 0; i < D; i++) begin
      check("drain data", rd_data, 8'h11 + i);
      step(0, 8'h00, 1, 0, 0);
    end
    check("drain empty", empty, 1);
    check("drain used",  used,  0);
    step(0, 8'h00, 0, 0, 1);
    check("clr ovf", overflow, 0);
    check("clr max", max_used, 0);

    // Simultaneous traffic at used=3.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("simul data", rd_data, 8'h20 + i);
      step(1, 8'(8'h23 + i), 1, 0, 0);
      check("simul used", used, 3);
    end
    check("simul ovf", overflow,  0);
    check("simul udf", underflow, 0);
    check("simul head", rd_data,  8'h2A);

    // Write+read at full with stat_clr: read taken, write refused, set wins.
    step(1, 8'h2D, 0, 0, 0);
    step(1, 8'h2E, 0, 0, 0);
    check("at full", full, 1);
    step(1, 8'h77, 1, 0, 1);
    check("wr/rd full used", used,     4);
    check("wr/rd full ovf",  overflow, 1);
    check("wr/rd full max",  max_used, 4);
    check("wr/rd full head", rd_data,  8'h2B);

    // Flush with requests in the same cycle.
    step(1, 8'h55, 1, 1, 0);
    check("flush empty", empty,     1);
    check("flush used",  used,      0);
    check("flush full",  full,      0);
    check("flush ovf",   overflow,  1);
    check("flush udf",   underflow, 0);
    check("flush max",   max_used,  4);
    step(0, 8'h00, 0, 0, 1);
    check("post clr max", max_used, 0);
    check("post clr ovf", overflow, 0);

    // Randomized traffic with drifting write/read bias.
    wp = 50;
    rp = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        wp = $urandom_range(90, 10);
        rp = $urandom_range(90, 10);
      end
      rst = ($urandom_range(1999) == 0);
      step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
           $urandom_range(63) == 0, $urandom_range(31) == 0);
    end
    rst = 1'b0;
    repeat (3) step(0, 8'h00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
